// File: rtl/vending_ctrl.sv
// -----------------------------------------------------------------------------
// vending_ctrl -- multi-item vending controller
//
// Collects 5/10/25 coins into a credit register, vends the selected item when
// credit covers its price, and returns leftover credit as a contiguous train of
// change_5 pulses. A cancel in COLLECT refunds the whole credit the same way.
//
// Optional feature: define STOCK_EN to add per-item stock counters, the
// sold_out pulse and the restock input. Without it, restock is ignored and
// sold_out is constant 0.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   coin_valid     one-cycle coin strobe, coin_val = 5, 10 or 25
//   sel_valid      one-cycle select strobe, sel_item = item index
//   cancel         one-cycle refund request
//   restock        reload all stock counters (STOCK_EN only)
//   credit         current credit (registered)
//   busy           high in VEND and CHANGE
//   coin_reject    pulse: coin refused
//   insufficient   pulse: selection refused, credit < price or bad index
//   sold_out       pulse: selection refused, item stock is 0
//   dispense       pulse: vend, dispense_item holds the item index
//   change_5       pulse: one 5-unit coin returned
// -----------------------------------------------------------------------------
module vending_ctrl #(
    parameter int                         NUM_ITEMS   = 4,
    parameter int                         PRICE_W     = 8,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_TABLE = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int                         MAX_CREDIT  = 100,
    parameter int                         STOCK_INIT  = 3,
    parameter int                         SEL_W       = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin_valid,
    input  logic [4:0]         coin_val,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel_item,
    input  logic               cancel,
    input  logic               restock,
    output logic [PRICE_W-1:0] credit,
    output logic               busy,
    output logic               coin_reject,
    output logic               insufficient,
    output logic               sold_out,
    output logic               dispense,
    output logic [SEL_W-1:0]   dispense_item,
    output logic               change_5
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    // One extra bit so credit + coin never wraps before the ceiling compare.
    localparam int CW = PRICE_W + 1;

    state_t             state, state_nxt;
    logic [PRICE_W-1:0] price;
    logic               sel_hit;
    logic               stock_empty;
    logic [CW-1:0]      credit_sum;
    logic               coin_ok;

    // Decisions made by the next-state logic, consumed by the output logic.
    logic               coin_acc, coin_rej, sel_short, sel_empty, vend_go;

    logic [PRICE_W-1:0] credit_nxt;
    logic               busy_nxt, coin_reject_nxt, insufficient_nxt, sold_out_nxt;
    logic               dispense_nxt, change_5_nxt;
    logic [SEL_W-1:0]   dispense_item_nxt;

    // Price lookup; sel_hit is low for an index beyond the table.
    always_comb begin
        price   = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == SEL_W'(i)) begin
                price   = PRICE_TABLE[i*PRICE_W +: PRICE_W];
                sel_hit = 1'b1;
            end
        end
    end

    assign credit_sum = CW'(credit) + CW'(coin_val);
    assign coin_ok    = ((coin_val == 5'd5) || (coin_val == 5'd10) || (coin_val == 5'd25))
                        && (credit_sum <= CW'(MAX_CREDIT));

`ifdef STOCK_EN
    localparam int STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

    logic [STOCK_W-1:0] stock [NUM_ITEMS];

    always_comb begin
        stock_empty = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item == SEL_W'(i)) stock_empty = (stock[i] == '0);
        end
    end

    // NOTE: the stock array is functional state, so unlike a data memory it is
    // reset; a vend after reset must see STOCK_INIT, not power-up garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end else if (vend_go) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (sel_item == SEL_W'(i)) stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end
`else
    logic          unused_restock;
    localparam int unused_stock_init = STOCK_INIT;

    assign unused_restock = restock;
    assign stock_empty    = 1'b0;
`endif

    // State and registered outputs.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            busy          <= 1'b0;
            coin_reject   <= 1'b0;
            insufficient  <= 1'b0;
            sold_out      <= 1'b0;
            dispense      <= 1'b0;
            dispense_item <= '0;
            change_5      <= 1'b0;
        end else begin
            state         <= state_nxt;
            credit        <= credit_nxt;
            busy          <= busy_nxt;
            coin_reject   <= coin_reject_nxt;
            insufficient  <= insufficient_nxt;
            sold_out      <= sold_out_nxt;
            dispense      <= dispense_nxt;
            dispense_item <= dispense_item_nxt;
            change_5      <= change_5_nxt;
        end
    end

    // Next-state logic. Priority in COLLECT: cancel > select > coin; a coin
    // arriving alongside cancel or select is always refused.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        coin_acc  = 1'b0;
        coin_rej  = 1'b0;
        sel_short = 1'b0;
        sel_empty = 1'b0;
        vend_go   = 1'b0;
        case (state)
            IDLE: begin
                if (coin_valid) begin
                    if (coin_ok) begin
                        coin_acc  = 1'b1;
                        state_nxt = COLLECT;
                    end else begin
                        coin_rej = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    coin_rej  = coin_valid;
                    state_nxt = CHANGE;
                end else if (sel_valid) begin
                    coin_rej = coin_valid;
                    if (!sel_hit)                 sel_short = 1'b1;
                    else if (stock_empty)         sel_empty = 1'b1;
                    else if (credit < price)      sel_short = 1'b1;
                    else begin
                        vend_go   = 1'b1;
                        state_nxt = VEND;
                    end
                end else if (coin_valid) begin
                    coin_acc = coin_ok;
                    coin_rej = !coin_ok;
                end
            end
            VEND, CHANGE: begin
                // credit already reflects the pulse shown this cycle, so a
                // zero here means the refund is complete.
                coin_rej  = coin_valid;
                state_nxt = (credit != '0) ? CHANGE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        credit_nxt = credit;
        if (coin_acc)                credit_nxt = credit_sum[PRICE_W-1:0];
        else if (vend_go)            credit_nxt = credit - price;
        else if (state_nxt == CHANGE) credit_nxt = credit - PRICE_W'(5);

        change_5_nxt      = (state_nxt == CHANGE);
        busy_nxt          = (state_nxt == VEND) || (state_nxt == CHANGE);
        dispense_nxt      = vend_go;
        dispense_item_nxt = vend_go ? sel_item : '0;
        coin_reject_nxt   = coin_rej;
        insufficient_nxt  = sel_short;
        sold_out_nxt      = sel_empty;
    end

endmodule

// File: tb/tb_vending_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for vending_ctrl (default parameters: prices 15/20/25/30,
// ceiling 100). Stimulus pushes the expected pulse cycles into a queue; the
// monitor pops one entry per cycle in which any pulse output is high.
// -----------------------------------------------------------------------------
module tb_vending_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [4:0] coin_val = '0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = '0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic [7:0] credit;
    logic       busy, coin_reject, insufficient, sold_out, dispense, change_5;
    logic [1:0] dispense_item;

    vending_ctrl dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_item(sel_item),
        .cancel(cancel), .restock(restock),
        .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .insufficient(insufficient),
        .sold_out(sold_out), .dispense(dispense),
        .dispense_item(dispense_item), .change_5(change_5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] pulses;   // {coin_reject, insufficient, sold_out, dispense, change_5}
        logic [1:0] item;
        logic [7:0] credit;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- expectation helpers ----------------
    task automatic push(input logic [4:0] p, input logic [1:0] it, input logic [7:0] cr, input logic b);
        exp_t e;
        e.pulses = p; e.item = it; e.credit = cr; e.busy = b;
        sb_q.push_back(e);
    endtask

    // change pulses from (start-5) down to 0
    task automatic push_change_run(input int start);
        for (int c = start - 5; c >= 0; c -= 5) push(5'b00001, 2'd0, 8'(c), 1'b1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (coin_reject | insufficient | sold_out | dispense | change_5) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got %b expected none at %0t",
                             {coin_reject, insufficient, sold_out, dispense, change_5}, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("pulses", 32'({coin_reject, insufficient, sold_out, dispense, change_5}),
                          32'(e.pulses));
                    check("credit_at_pulse", 32'(credit), 32'(e.credit));
                    check("busy_at_pulse", 32'(busy), 32'(e.busy));
                    if (e.pulses[1]) check("dispense_item", 32'(dispense_item), 32'(e.item));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic coin(input logic [4:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0; coin_val = '0;
    endtask

    task automatic sel(input logic [1:0] i);
        sel_valid = 1'b1; sel_item = i;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_credit"}, 32'(credit), 0);
        check({name, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed test sequence ----------------
    initial begin
        // Reset state
        idle(3);
        check("rst_credit", 32'(credit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pulses", 32'({coin_reject, insufficient, sold_out, dispense, change_5}), 0);
        check("rst_item", 32'(dispense_item), 0);
        rst = 1'b0;
        tick();

        // 1: 10 + 5, buy item 0 (15): exact, no change
        coin(5'd10); check("t1_credit10", 32'(credit), 10);
        coin(5'd5);  check("t1_credit15", 32'(credit), 15);
        push(5'b00010, 2'd0, 8'd0, 1'b1);
        sel(2'd0);
        tick(); check_idle("t1_end");

        // Select and cancel in IDLE are ignored (monitor flags any pulse)
        sel(2'd1); do_cancel(); tick(); check_idle("idle_ignore");

        // Exact price of item 2 (25)
        coin(5'd25);
        push(5'b00010, 2'd2, 8'd0, 1'b1);
        sel(2'd2);
        tick(); check_idle("t1b_end");

        // Boundary: credit == price for item 3 (30)
        coin(5'd25); coin(5'd5); check("t1c_credit30", 32'(credit), 30);
        push(5'b00010, 2'd3, 8'd0, 1'b1);
        sel(2'd3);
        tick(); check_idle("t1c_end");

        // 2: 25, buy item 0 -> two change pulses
        coin(5'd25);
        push(5'b00010, 2'd0, 8'd10, 1'b1);
        push_change_run(10);
        sel(2'd0);
        idle(3); check_idle("t2_end");

        // 3: 10, item 3 (30) insufficient, then cancel
        coin(5'd10);
        push(5'b01000, 2'd0, 8'd10, 1'b0);
        sel(2'd3);
        tick(); check("t3_credit_kept", 32'(credit), 10);
        push_change_run(10);
        do_cancel();
        idle(2); check_idle("t3_end");

        // 4: illegal coin, ceiling, coin during CHANGE
        push(5'b10000, 2'd0, 8'd0, 1'b0);
        coin(5'd7);
        check("t4_credit_after7", 32'(credit), 0);
        coin(5'd25); coin(5'd25); coin(5'd25); coin(5'd10); coin(5'd10);
        check("t4_credit95", 32'(credit), 95);
        push(5'b10000, 2'd0, 8'd95, 1'b0);
        coin(5'd10);
        check("t4_credit_kept95", 32'(credit), 95);
        coin(5'd5);
        check("t4_credit100", 32'(credit), 100);
        push(5'b10000, 2'd0, 8'd100, 1'b0);
        coin(5'd5);
        push(5'b00001, 2'd0, 8'd95, 1'b1);
        push(5'b10001, 2'd0, 8'd90, 1'b1);
        push_change_run(90);
        do_cancel();
        coin(5'd10);
        idle(19); check_idle("t4_end");

        // 5a: cancel beats select and coin in the same cycle
        coin(5'd10);
        push(5'b10001, 2'd0, 8'd5, 1'b1);
        push(5'b00001, 2'd0, 8'd0, 1'b1);
        cancel = 1'b1; sel_valid = 1'b1; sel_item = 2'd3; coin_valid = 1'b1; coin_val = 5'd5;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
        idle(2); check_idle("t5a_end");

        // 5b: coin with a short select -> insufficient + coin_reject
        coin(5'd10);
        push(5'b11000, 2'd0, 8'd10, 1'b0);
        sel_valid = 1'b1; sel_item = 2'd0; coin_valid = 1'b1; coin_val = 5'd5;
        tick();
        sel_valid = 1'b0; coin_valid = 1'b0; coin_val = '0;
        check("t5b_credit_kept", 32'(credit), 10);

        // 5c: reset in the middle of a refund
        coin(5'd25);
        check("t5c_credit35", 32'(credit), 35);
        push(5'b00001, 2'd0, 8'd30, 1'b1);
        push(5'b00001, 2'd0, 8'd25, 1'b1);
        do_cancel();
        tick(); tick();
        rst = 1'b1;
        #1;
        check("t5c_rst_credit", 32'(credit), 0);
        check("t5c_rst_busy", 32'(busy), 0);
        check("t5c_rst_change", 32'(change_5), 0);
        idle(2);
        rst = 1'b0;
        tick();
        check("t5c_after_change", 32'(change_5), 0);
        coin(5'd5);
        check("t5c_credit5", 32'(credit), 5);
        push(5'b00001, 2'd0, 8'd0, 1'b1);
        do_cancel();
        idle(2); check_idle("t5c_end");

`ifdef STOCK_EN
        // 6: item 1 (20) three times with a 25 coin, then sold out, restock
        for (int n = 0; n < 3; n++) begin
            coin(5'd25);
            push(5'b00010, 2'd1, 8'd5, 1'b1);
            push(5'b00001, 2'd0, 8'd0, 1'b1);
            sel(2'd1);
            idle(2); check_idle("t6_vend");
        end
        coin(5'd25);
        push(5'b00100, 2'd0, 8'd25, 1'b0);
        sel(2'd1);
        check("t6_credit_kept", 32'(credit), 25);
        restock = 1'b1; tick(); restock = 1'b0;
        push(5'b00010, 2'd1, 8'd5, 1'b1);
        push(5'b00001, 2'd0, 8'd0, 1'b1);
        sel(2'd1);
        idle(2); check_idle("t6_end");
`endif

        idle(3);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
